// File: rtl/mips_rtype_multicycle.sv
// mips_rtype_multicycle
//   Multi-cycle R-type MIPS core. Each instruction walks through
//   FETCH -> DECODE -> EXECUTE -> WRITEBACK. It reads from an internal
//   instruction memory (instBank) and works on an internal register bank
//   (registerBank). Neither array is cleared by reset, so contents written
//   in from outside before reset is released are kept.
//
//   Supported funct codes: add, sub, and, or, xor, nor, slt, sll, srl.
//   Opcode 6'b111111 is halt. Any other opcode or funct sets the sticky
//   illegal flag and the instruction is skipped. When pc runs past the end
//   of instBank, the core also halts.
//
// Ports
//   clk_CPU    in   1       single clock, rising edge
//   rst_CPU    in   1       synchronous, active-high reset
//   resultado  out  DATA_W  last ALU result committed in WRITEBACK
//   pc         out  32      byte address of the current instruction
//   halted     out  1       high while in HALT
//   illegal    out  1       sticky: an unsupported opcode or funct was seen
//   retired    out  CNT_W   count of committed R-type instructions
module mips_rtype_multicycle #(
  parameter int DATA_W     = 32,
  parameter int NUM_REGS   = 32,
  parameter int IMEM_DEPTH = 64,
  parameter int CNT_W      = 16
) (
  input  logic              clk_CPU,
  input  logic              rst_CPU,
  output logic [DATA_W-1:0] resultado,
  output logic [31:0]       pc,
  output logic              halted,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired
);

  localparam int IA_W  = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int RA_W0 = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  // Register fields in the instruction are only 5 bits wide.
  localparam int RA_W  = (RA_W0 > 5) ? 5 : RA_W0;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // FETCH must be the first encoding: reset places the FSM in state 0.
  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    WRITEBACK = 3'd3,
    HALT      = 3'd4
  } state_t;

  logic [31:0]       instBank     [0:IMEM_DEPTH-1];
  logic [DATA_W-1:0] registerBank [0:NUM_REGS-1];

  state_t state, state_nx;

  logic [31:0]              ir;
  logic signed [DATA_W-1:0] op_a;
  logic signed [DATA_W-1:0] op_b;
  logic [DATA_W-1:0]        alu_out;

  logic ld_ir, ld_ab, ld_alu, do_wb, pc_inc, set_illegal;

  logic [5:0] opcode;
  logic [4:0] rs, rt, rd, shamt;
  logic [5:0] funct;

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign shamt  = ir[10:6];
  assign funct  = ir[5:0];

  // Register 0 and any index past the end of the bank read as zero.
  // Writes to those indices are ignored.
  function automatic logic reg_ok(input logic [4:0] idx);
    logic [31:0] idx_w;
    idx_w = {27'b0, idx};
    return (idx_w != 32'd0) && (idx_w < NUM_REGS);
  endfunction

  function automatic logic funct_ok(input logic [5:0] fn);
    logic ok;
    unique case (fn)
      FN_SLL, FN_SRL, FN_ADD, FN_SUB, FN_AND,
      FN_OR,  FN_XOR, FN_NOR, FN_SLT: ok = 1'b1;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Add and sub wrap modulo 2^DATA_W, with no overflow trap.
  // slt is a signed compare.
  // Shift amounts of DATA_W or more flush the result to zero.
  function automatic logic [DATA_W-1:0] alu_fn(
    input logic [5:0]               fn,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b,
    input logic [4:0]               sh
  );
    logic [DATA_W-1:0] res;
    logic              sh_big;
    logic              lt;
    sh_big = ({27'b0, sh} >= DATA_W);
    lt     = (a < b);
    res    = '0;
    unique case (fn)
      FN_ADD:  res = a + b;
      FN_SUB:  res = a - b;
      FN_AND:  res = a & b;
      FN_OR:   res = a | b;
      FN_XOR:  res = a ^ b;
      FN_NOR:  res = ~(a | b);
      FN_SLT:  res = {{(DATA_W-1){1'b0}}, lt};
      FN_SLL:  res = sh_big ? '0 : (DATA_W'(b) << sh);
      FN_SRL:  res = sh_big ? '0 : (DATA_W'(b) >> sh);
      default: res = '0;
    endcase
    return res;
  endfunction

  logic        fetch_oob;
  logic [31:0] fetch_word;
  logic [DATA_W-1:0] rs_val, rt_val;

  assign fetch_oob  = ({2'b00, pc[31:2]} >= IMEM_DEPTH);
  assign fetch_word = instBank[pc[IA_W+1:2]];
  assign rs_val     = reg_ok(rs) ? registerBank[rs[RA_W-1:0]] : '0;
  assign rt_val     = reg_ok(rt) ? registerBank[rt[RA_W-1:0]] : '0;

  // State register
  always_ff @(posedge clk_CPU) begin
    if (rst_CPU) state <= FETCH;
    else         state <= state_nx;
  end

  // Next-state and datapath enables
  always_comb begin
    state_nx    = state;
    ld_ir       = 1'b0;
    ld_ab       = 1'b0;
    ld_alu      = 1'b0;
    do_wb       = 1'b0;
    pc_inc      = 1'b0;
    set_illegal = 1'b0;
    unique case (state)
      FETCH: begin
        if (fetch_oob) begin
          state_nx = HALT;
        end else begin
          ld_ir    = 1'b1;
          state_nx = DECODE;
        end
      end
      DECODE: begin
        ld_ab = 1'b1;
        if (opcode == OP_RTYPE) begin
          state_nx = EXECUTE;
        end else if (opcode == OP_HALT) begin
          state_nx = HALT;
        end else begin
          set_illegal = 1'b1;
          pc_inc      = 1'b1;
          state_nx    = FETCH;
        end
      end
      EXECUTE: begin
        if (funct_ok(funct)) begin
          ld_alu   = 1'b1;
          state_nx = WRITEBACK;
        end else begin
          set_illegal = 1'b1;
          pc_inc      = 1'b1;
          state_nx    = FETCH;
        end
      end
      WRITEBACK: begin
        do_wb    = 1'b1;
        pc_inc   = 1'b1;
        state_nx = FETCH;
      end
      HALT:    state_nx = HALT;
      default: state_nx = FETCH;
    endcase
  end

  // Datapath and architectural outputs
  always_ff @(posedge clk_CPU) begin
    if (rst_CPU) begin
      pc        <= 32'd0;
      resultado <= '0;
      illegal   <= 1'b0;
      retired   <= '0;
      ir        <= 32'd0;
      op_a      <= '0;
      op_b      <= '0;
      alu_out   <= '0;
    end else begin
      if (ld_ir)       ir      <= fetch_word;
      if (ld_ab) begin
        op_a <= rs_val;
        op_b <= rt_val;
      end
      if (ld_alu)      alu_out <= alu_fn(funct, op_a, op_b, shamt);
      if (set_illegal) illegal <= 1'b1;
      if (pc_inc)      pc      <= pc + 32'd4;
      if (do_wb) begin
        resultado <= alu_out;
        retired   <= retired + CNT_W'(1);
      end
    end
  end

  // Register-bank write port. It is not reset so preloaded values survive,
  // and it is blocked while reset is asserted.
  always_ff @(posedge clk_CPU) begin
    if (!rst_CPU && do_wb && reg_ok(rd))
      registerBank[rd[RA_W-1:0]] <= alu_out;
  end

  assign halted = (state == HALT);

endmodule

// File: doc/mips_rtype_multicycle.md
Name: mips_rtype_multicycle

Overview:
Parametrised multi-cycle successor to the single-cycle R-type CPU (CPUControlRType). It executes R-type MIPS instructions from an internal instruction memory against an internal register bank, using a 4-state FETCH/DECODE/EXECUTE/WRITEBACK FSM. Compared with the single-cycle datapath it adds:
- configurable data width and memory depths
- synchronous reset
- shift and xor functions
- illegal-instruction flagging
- a halt instruction
- end-of-memory stop
- a retired-instruction counter

Benches preload `instBank` and `registerBank` hierarchically with $readmemb. Those array names are therefore fixed.

Parameters:
- DATA_W, 32: datapath and register width; must be ≥ 6.
- NUM_REGS, 32: register count; rs/rt/rd index fields above NUM_REGS-1 read as 0 and do not write.
- IMEM_DEPTH, 64: instruction words in `instBank`, each 32 bits wide.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk_CPU  in  1  Single clock; all state updates on the rising edge.
- rst_CPU  in  1  Synchronous, active-high reset.
- resultado  out  DATA_W  Last ALU result committed in WRITEBACK.
- pc  out  32  Byte address of the current instruction.
- halted  out  1  High while in HALT.
- illegal  out  1  Sticky flag: an unsupported opcode or funct was seen.
- retired  out  CNT_W  Count of committed R-type instructions.

Behaviour:
- Reset (rst_CPU=1 at a rising edge):
  - state=FETCH; pc=0; resultado=0; halted=0; illegal=0; retired=0; IR/A/B/ALUOut=0.
  - `registerBank` and `instBank` are NOT cleared, so preloaded contents survive.
  - Reset overrides any state, including HALT and a mid-instruction state. No register write happens in the reset cycle.
- FETCH:
  - If pc[31:2] ≥ IMEM_DEPTH: go to HALT (end-of-memory stop).
  - Else: IR ← instBank[pc[31:2]]; go to DECODE.
- DECODE:
  - A ← reg[rs]; B ← reg[rt].
  - reg[0] always reads 0.
  - Next state is chosen by opcode IR[31:26]:
    - 6'b000000: EXECUTE.
    - 6'b111111: HALT.
    - Anything else: set illegal=1, pc ← pc+4, go to FETCH. No write.
- EXECUTE: ALUOut ← f(A,B,shamt) by funct IR[5:0]:
  - 100000 add, 100010 sub: wrap modulo 2^DATA_W, no overflow trap.
  - 100100 and, 100101 or, 100110 xor, 100111 nor.
  - 101010 slt: signed compare, result 1 or 0, zero-extended.
  - 000000 sll: B<<shamt. 000010 srl: B>>shamt, logical. shamt=IR[10:6]; shifts ≥ DATA_W give 0.
  - Unsupported funct: set illegal=1, pc ← pc+4, go to FETCH. No write, retired unchanged.
- WRITEBACK:
  - reg[rd] ← ALUOut, unless rd=0 or rd ≥ NUM_REGS.
  - resultado ← ALUOut, even when rd=0.
  - retired ← retired+1, wrapping at 2^CNT_W.
  - pc ← pc+4; go to FETCH.
- HALT: halted=1. pc, registers, resultado and retired are frozen until reset.
- Timing:
  - A legal instruction takes exactly 4 cycles.
  - Its result is visible on resultado and in registerBank after the 4th rising edge from its FETCH edge.
  - An illegal instruction costs 2 cycles (FETCH, DECODE) if its opcode is bad, 3 if its funct is bad.
  - Halt is reached 2 cycles after its FETCH.
- Outputs are registered only; there are no combinational paths from inputs to outputs.
- Register-bank read and write in the same cycle cannot occur, because the FSM separates DECODE from WRITEBACK.

Test Plan:
- Preload $1=5, $2=3; instBank[0]=0x00221820 (add $3,$1,$2), instBank[1]=0x00222022 (sub $4,$1,$2), instBank[2]=0x0041282A (slt $5,$2,$1), instBank[3]=0xFC000000, then release reset.
  - resultado goes 8, 2, 1 at cycles 4, 8 and 12 after reset.
  - Registers: $3=8, $4=2, $5=1.
  - retired=3; halted=1 at cycle 14; pc=12 and frozen.
- add $0,$1,$2 (0x00220020) -> resultado=8, registerBank[0] stays 0, retired=1.
- sll $6,$1,2 (0x00013080) -> $6=20. Then srl $7,$1,1 (0x00013842) -> $7=2.
- sub $8,$2,$1 (0x00414022) -> $8=0xFFFFFFFE. Then slt $9,$8,$2 (0x0102482A) -> $9=1 (signed compare).
- Illegal cases:
  - 0x8C220000 (lw opcode): illegal=1, pc advances by 4 after 2 cycles, no register change, retired=0.
  - Funct 0x3F: illegal=1 after 3 cycles.
  - illegal stays high through later legal instructions.
- End-of-memory and reset:
  - IMEM_DEPTH=4 with 4 legal adds: halted=1 at the FETCH where pc=16; retired=4.
  - Assert rst_CPU during an EXECUTE cycle: the next cycle shows pc=0, resultado=0, retired=0, state=FETCH, and preloaded registers are unchanged.
